// File: rtl/wb_regfile_pkg.sv
// Shared types and constants for the writeback stage and register file.
package wb_regfile_pkg;

  typedef enum logic [2:0] {
    WB_ALU   = 3'd0,
    WB_MEM   = 3'd1,
    WB_LINK  = 3'd2,
    WB_IMM   = 3'd3,
    WB_PCIMM = 3'd4
  } wb_src_t;

  localparam logic [4:0]  REG_ZERO    = 5'd0;
  localparam int unsigned LINK_OFFSET = 4;

endpackage

// File: rtl/wb_regfile_mux.sv
// Writeback source select: picks ALU, load, link, LUI or AUIPC value.
module wb_mux
  import wb_regfile_pkg::*;
#(
  parameter int unsigned DM_ADDRESS = 9,
  parameter int unsigned DATA_W     = 32
) (
  input  logic [2:0]            src_i,
  input  logic [DM_ADDRESS-1:0] pc_i,
  input  logic [DATA_W-1:0]     imm_i,
  input  logic [DATA_W-1:0]     alu_i,
  input  logic [DATA_W-1:0]     mem_i,
  output logic [DATA_W-1:0]     wb_data_o
);

  wb_src_t           src;
  logic [DATA_W-1:0] pc_ext;

  assign src    = wb_src_t'(src_i);
  // PC is zero-extended so link/AUIPC sums never pick up sign bits.
  assign pc_ext = DATA_W'(pc_i);

  always_comb begin
    wb_data_o = alu_i;
    case (src)
      WB_ALU:   wb_data_o = alu_i;
      WB_MEM:   wb_data_o = mem_i;
      WB_LINK:  wb_data_o = pc_ext + DATA_W'(LINK_OFFSET);
      WB_IMM:   wb_data_o = imm_i;
      WB_PCIMM: wb_data_o = pc_ext + imm_i;
      default:  wb_data_o = alu_i;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage plus 32x32 register file with write-through read bypass,
// forwarding outputs, a registered commit trace and a commit counter.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int unsigned DM_ADDRESS = 9,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     MemRdDataIn,
  input  logic [DATA_W-1:0]     MemALUresultIn,
  input  logic                  RegWrtEnIn,
  input  logic [2:0]            RegWrtSrcIn,
  input  logic [4:0]            RegDstIn,
  input  logic [DM_ADDRESS-1:0] PCin,
  input  logic [DATA_W-1:0]     immIn,
  input  logic [4:0]            RdAddrA,
  input  logic [4:0]            RdAddrB,
  output logic [DATA_W-1:0]     RdDataA,
  output logic [DATA_W-1:0]     RdDataB,
  output logic [DATA_W-1:0]     WBDataOut,
  output logic [4:0]            WBDstOut,
  output logic                  WBEnOut,
  output logic                  TraceValid,
  output logic [4:0]            TraceDst,
  output logic [DATA_W-1:0]     TraceData,
  output logic [31:0]           CommitCount
);

  logic [DATA_W-1:0] wb_data;
  logic              wen;

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  logic              trace_valid_q, trace_valid_d;
  logic [4:0]        trace_dst_q,   trace_dst_d;
  logic [DATA_W-1:0] trace_data_q,  trace_data_d;
  logic [31:0]       commit_cnt_q,  commit_cnt_d;

  wb_mux #(
    .DM_ADDRESS (DM_ADDRESS),
    .DATA_W     (DATA_W)
  ) u_mux (
    .src_i     (RegWrtSrcIn),
    .pc_i      (PCin),
    .imm_i     (immIn),
    .alu_i     (MemALUresultIn),
    .mem_i     (MemRdDataIn),
    .wb_data_o (wb_data)
  );

  // Reset gates the enable so an in-flight writeback is dropped.
  assign wen = RegWrtEnIn && (RegDstIn != REG_ZERO) && !rst;

  assign WBDataOut = wb_data;
  assign WBDstOut  = RegDstIn;
  assign WBEnOut   = wen;

  always_comb begin
    RdDataA = '0;
    if (!rst && (RdAddrA != REG_ZERO)) begin
      if (wen && (RdAddrA == RegDstIn)) RdDataA = wb_data;
      else                              RdDataA = regs_q[RdAddrA];
    end
  end

  always_comb begin
    RdDataB = '0;
    if (!rst && (RdAddrB != REG_ZERO)) begin
      if (wen && (RdAddrB == RegDstIn)) RdDataB = wb_data;
      else                              RdDataB = regs_q[RdAddrB];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wen) begin
      regs_q[RegDstIn] <= wb_data;
    end
  end

  always_comb begin
    trace_valid_d = wen;
    trace_dst_d   = trace_dst_q;
    trace_data_d  = trace_data_q;
    commit_cnt_d  = commit_cnt_q;
    if (wen) begin
      trace_dst_d  = RegDstIn;
      trace_data_d = wb_data;
      commit_cnt_d = commit_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trace_valid_q <= 1'b0;
      trace_dst_q   <= '0;
      trace_data_q  <= '0;
      commit_cnt_q  <= '0;
    end else begin
      trace_valid_q <= trace_valid_d;
      trace_dst_q   <= trace_dst_d;
      trace_data_q  <= trace_data_d;
      commit_cnt_q  <= commit_cnt_d;
    end
  end

  assign TraceValid  = trace_valid_q;
  assign TraceDst    = trace_dst_q;
  assign TraceData   = trace_data_q;
  assign CommitCount = commit_cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: vector table for the mux/bypass path plus
// hand-written reset, trace, counter-wrap and mid-stream reset sequences.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] MemRdDataIn, MemALUresultIn, immIn;
  logic        RegWrtEnIn;
  logic [2:0]  RegWrtSrcIn;
  logic [4:0]  RegDstIn, RdAddrA, RdAddrB;
  logic [8:0]  PCin;
  logic [31:0] RdDataA, RdDataB, WBDataOut, TraceData, CommitCount;
  logic [4:0]  WBDstOut, TraceDst;
  logic        WBEnOut, TraceValid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_regfile #(.DM_ADDRESS(9), .DATA_W(32), .NUM_REGS(32)) dut (
    .clk(clk), .rst(rst),
    .MemRdDataIn(MemRdDataIn), .MemALUresultIn(MemALUresultIn),
    .RegWrtEnIn(RegWrtEnIn), .RegWrtSrcIn(RegWrtSrcIn), .RegDstIn(RegDstIn),
    .PCin(PCin), .immIn(immIn), .RdAddrA(RdAddrA), .RdAddrB(RdAddrB),
    .RdDataA(RdDataA), .RdDataB(RdDataB), .WBDataOut(WBDataOut),
    .WBDstOut(WBDstOut), .WBEnOut(WBEnOut), .TraceValid(TraceValid),
    .TraceDst(TraceDst), .TraceData(TraceData), .CommitCount(CommitCount)
  );

  typedef struct {
    logic        wen;
    logic [2:0]  src;
    logic [4:0]  dst;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [8:0]  pc;
    logic [31:0] imm;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [31:0] ewb;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic wen, input logic [2:0] src, input logic [4:0] dst,
                       input logic [31:0] alu, input logic [4:0] ra, input logic [4:0] rb);
    RegWrtEnIn     = wen;
    RegWrtSrcIn    = src;
    RegDstIn       = dst;
    MemALUresultIn = alu;
    RdAddrA        = ra;
    RdAddrB        = rb;
  endtask

  initial begin
    int exp_commits;
    logic exp_en;

    rst = 1'b1;
    MemRdDataIn = 32'h22; PCin = 9'h010; immIn = 32'h1000;
    drive(1'b1, 3'd0, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5);

    // Reset holds writes off and reads at zero.
    tick(); tick();
    #1;
    check("rst_rda", RdDataA, 32'h0);
    check("rst_rdb", RdDataB, 32'h0);
    check("rst_wben", {31'b0, WBEnOut}, 32'h0);
    check("rst_cnt", CommitCount, 32'h0);
    check("rst_tv", {31'b0, TraceValid}, 32'h0);

    rst = 1'b0;
    drive(1'b1, 3'd0, 5'd0, 32'h12345678, 5'd0, 5'd5);
    #1;
    check("x0_wben", {31'b0, WBEnOut}, 32'h0);
    check("x0_rda", RdDataA, 32'h0);
    tick();
    check("x0_after_rda", RdDataA, 32'h0);
    check("x5_after_rdb", RdDataB, 32'h0);
    check("x0_tv", {31'b0, TraceValid}, 32'h0);
    check("x0_cnt", CommitCount, 32'h0);

    // wen src dst alu mem pc imm ra rb ea eb ewb
    vecs[0]  = '{1'b1, 3'd0, 5'd1,  32'h11, 32'h22, 9'h010, 32'h1000, 5'd1,  5'd0,  32'h11,   32'h0,    32'h11};
    vecs[1]  = '{1'b1, 3'd1, 5'd2,  32'h11, 32'h22, 9'h010, 32'h1000, 5'd1,  5'd2,  32'h11,   32'h22,   32'h22};
    vecs[2]  = '{1'b1, 3'd2, 5'd3,  32'h11, 32'h22, 9'h010, 32'h1000, 5'd3,  5'd2,  32'h14,   32'h22,   32'h14};
    vecs[3]  = '{1'b1, 3'd3, 5'd4,  32'h11, 32'h22, 9'h010, 32'h1000, 5'd4,  5'd3,  32'h1000, 32'h14,   32'h1000};
    vecs[4]  = '{1'b1, 3'd4, 5'd5,  32'h11, 32'h22, 9'h010, 32'h1000, 5'd5,  5'd1,  32'h1010, 32'h11,   32'h1010};
    vecs[5]  = '{1'b1, 3'd7, 5'd6,  32'h33, 32'h22, 9'h010, 32'h1000, 5'd6,  5'd4,  32'h33,   32'h1000, 32'h33};
    vecs[6]  = '{1'b0, 3'd0, 5'd6,  32'h55, 32'h22, 9'h010, 32'h1000, 5'd6,  5'd5,  32'h33,   32'h1010, 32'h55};
    vecs[7]  = '{1'b1, 3'd5, 5'd8,  32'h44, 32'h22, 9'h010, 32'h1000, 5'd8,  5'd0,  32'h44,   32'h0,    32'h44};
    vecs[8]  = '{1'b1, 3'd4, 5'd10, 32'h11, 32'h22, 9'h1FF, 32'hFFFFFFF0, 5'd10, 5'd8, 32'h1EF, 32'h44,   32'h1EF};
    vecs[9]  = '{1'b1, 3'd2, 5'd11, 32'h11, 32'h22, 9'h1FF, 32'h1000, 5'd11, 5'd10, 32'h203,  32'h1EF,  32'h203};
    vecs[10] = '{1'b1, 3'd6, 5'd0,  32'h77, 32'h22, 9'h010, 32'h1000, 5'd0,  5'd11, 32'h0,    32'h203,  32'h77};

    exp_commits = 0;
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].wen, vecs[i].src, vecs[i].dst, vecs[i].alu, vecs[i].ra, vecs[i].rb);
      MemRdDataIn = vecs[i].mem;
      PCin        = vecs[i].pc;
      immIn       = vecs[i].imm;
      exp_en      = vecs[i].wen && (vecs[i].dst != 5'd0);
      #1;
      check($sformatf("v%0d_rda", i), RdDataA, vecs[i].ea);
      check($sformatf("v%0d_rdb", i), RdDataB, vecs[i].eb);
      check($sformatf("v%0d_wb", i), WBDataOut, vecs[i].ewb);
      check($sformatf("v%0d_wben", i), {31'b0, WBEnOut}, {31'b0, exp_en});
      check($sformatf("v%0d_wbdst", i), {27'b0, WBDstOut}, {27'b0, vecs[i].dst});
      if (exp_en) exp_commits++;
      tick();
    end
    check("tbl_cnt", CommitCount, 32'(exp_commits));

    // Bypass: old value without enable, new value same-cycle with enable.
    MemRdDataIn = 32'h22; PCin = 9'h010; immIn = 32'h1000;
    drive(1'b0, 3'd0, 5'd7, 32'hCAFEF00D, 5'd7, 5'd7);
    #1;
    check("byp_old_a", RdDataA, 32'h0);
    check("byp_old_b", RdDataB, 32'h0);
    RegWrtEnIn = 1'b1;
    #1;
    check("byp_new_a", RdDataA, 32'hCAFEF00D);
    check("byp_new_b", RdDataB, 32'hCAFEF00D);
    tick();
    drive(1'b0, 3'd0, 5'd7, 32'h1, 5'd7, 5'd6);
    #1;
    check("byp_held_a", RdDataA, 32'hCAFEF00D);
    check("byp_held_b", RdDataB, 32'h33);

    // Trace and counter after a fresh reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 3'd0, 5'(i), 32'(i * 32'h101), 5'd0, 5'd0);
      tick();
      check($sformatf("tr%0d_tv", i), {31'b0, TraceValid}, 32'h1);
      check($sformatf("tr%0d_dst", i), {27'b0, TraceDst}, 32'(i));
      check($sformatf("tr%0d_data", i), TraceData, 32'(i * 32'h101));
    end
    drive(1'b0, 3'd0, 5'd4, 32'h999, 5'd1, 5'd3);
    tick();
    check("tr_idle_tv", {31'b0, TraceValid}, 32'h0);
    check("tr_idle_dst", {27'b0, TraceDst}, 32'h3);
    check("tr_idle_data", TraceData, 32'h303);
    check("tr_cnt", CommitCount, 32'h3);
    check("tr_x1", RdDataA, 32'h101);
    check("tr_x3", RdDataB, 32'h303);

    // Counter wrap via backdoor preload.
    force dut.commit_cnt_q = 32'hFFFFFFFF;
    #1;
    release dut.commit_cnt_q;
    #1;
    check("wrap_pre", CommitCount, 32'hFFFFFFFF);
    drive(1'b1, 3'd0, 5'd4, 32'h4444, 5'd0, 5'd0);
    tick();
    check("wrap_zero", CommitCount, 32'h0);
    tick();
    check("wrap_one", CommitCount, 32'h1);

    // Mid-stream reset drops the in-flight x9 write and clears everything.
    drive(1'b1, 3'd0, 5'd9, 32'hAA, 5'd9, 5'd1);
    tick();
    drive(1'b0, 3'd0, 5'd9, 32'h0, 5'd9, 5'd1);
    #1;
    check("mid_x9_aa", RdDataA, 32'hAA);
    drive(1'b1, 3'd0, 5'd9, 32'hBB, 5'd9, 5'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_wben", {31'b0, WBEnOut}, 32'h0);
    check("mid_rst_rda", RdDataA, 32'h0);
    tick();
    rst = 1'b0;
    drive(1'b0, 3'd0, 5'd9, 32'h0, 5'd9, 5'd1);
    #1;
    check("mid_x9", RdDataA, 32'h0);
    check("mid_x1", RdDataB, 32'h0);
    check("mid_tv", {31'b0, TraceValid}, 32'h0);
    check("mid_tdst", {27'b0, TraceDst}, 32'h0);
    check("mid_tdata", TraceData, 32'h0);
    check("mid_cnt", CommitCount, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback stage plus architectural register file. It sits directly downstream of the MEM/WB pipeline register and consumes its outputs: memory read data, ALU result, write-enable, write-source select, destination, PC and immediate.
- It selects the writeback value, commits it to a 32x32 register file on the clock edge, and serves two combinational read ports to decode with same-cycle write-through bypass.
- It also exports the writeback result to the EX forwarding unit and keeps a registered commit trace and a commit counter for verification.

Parameters:
- DM_ADDRESS, 9, PC width in bits.
- DATA_W, 32, datapath and register width.
- NUM_REGS, 32, number of architectural registers. Register 0 is hardwired to zero.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- MemRdDataIn  in  DATA_W  load data, already extended by MEM
- MemALUresultIn  in  DATA_W  ALU result
- RegWrtEnIn  in  1  writeback enable
- RegWrtSrcIn  in  3  writeback source select
- RegDstIn  in  5  destination register
- PCin  in  DM_ADDRESS  instruction PC
- immIn  in  DATA_W  immediate
- RdAddrA  in  5  read port A address
- RdAddrB  in  5  read port B address
- RdDataA  out  DATA_W  read port A data
- RdDataB  out  DATA_W  read port B data
- WBDataOut  out  DATA_W  selected writeback value (combinational), for forwarding
- WBDstOut  out  5  RegDstIn passthrough, for forwarding
- WBEnOut  out  1  effective write enable, for forwarding
- TraceValid  out  1  registered: a commit happened last cycle
- TraceDst  out  5  registered destination of last commit
- TraceData  out  DATA_W  registered data of last commit
- CommitCount  out  32  number of committed writes, wraps at 2^32

Behaviour:
- Writeback mux (combinational) on RegWrtSrcIn:
  - 000: MemALUresultIn
  - 001: MemRdDataIn
  - 010: zext(PCin) + 4, link value
  - 011: immIn, LUI
  - 100: zext(PCin) + immIn, AUIPC
  - 101..111: MemALUresultIn
  - All arithmetic is DATA_W wide modulo 2^DATA_W. PC is zero-extended before any addition.
- Effective write enable: wen = RegWrtEnIn AND (RegDstIn != 0) AND NOT rst.
- Commit:
  - On posedge clk with wen=1, regs[RegDstIn] takes the writeback value.
  - Writes to register 0 are discarded and produce no trace or count.
- Read ports (combinational):
  - Address 0 returns 0.
  - If wen=1 and the read address equals RegDstIn, the port returns the writeback value in the same cycle (write-through bypass).
  - Otherwise the port returns regs[addr].
  - Ports A and B are independent and may read the same address.
- Forwarding outputs:
  - WBDataOut is the mux value.
  - WBDstOut equals RegDstIn.
  - WBEnOut equals wen.
  - None of these outputs has latency.
- Trace: registered one cycle after commit.
  - TraceValid<=wen, TraceDst<=RegDstIn, TraceData<=writeback value.
  - When wen=0, TraceValid<=0 and TraceDst/TraceData hold their values.
- CommitCount increments by 1 on each commit edge with wen=1. It wraps from 0xFFFFFFFF to 0.
- Reset, synchronous:
  - On posedge clk with rst=1: all registers, TraceValid, TraceDst, TraceData and CommitCount become 0.
  - While rst=1: RdDataA/RdDataB read 0, WBEnOut=0, and no commit occurs even if RegWrtEnIn=1.
  - Reset asserted mid-stream drops the in-flight writeback.
  - First commit is possible on the first edge after rst deasserts.
- Latency: a register written at edge N is visible through the array from cycle N onward. Through the bypass it is visible in the cycle before edge N.

Decomposition:
- Shared package holds:
  - the wb_src_t enum: WB_ALU=3'd0, WB_MEM=3'd1, WB_LINK=3'd2, WB_IMM=3'd3, WB_PCIMM=3'd4
  - REG_ZERO=5'd0
  - LINK_OFFSET=4
- One sub-module, wb_mux: purely combinational source select and PC arithmetic.
- The register array, bypass, trace and counter live in wb_regfile.

Test Plan:
- Reset and register 0:
  - Stimulus: hold rst=1 with RegWrtEnIn=1, RegDst=5, ALU=0xDEADBEEF, then release rst. After release, write Dst=0 with ALU=0x12345678.
  - Required: during reset, reads of x5 give 0 and CommitCount=0. After release, a read of x0 gives 0, TraceValid=0 and CommitCount stays 0.
- Source select: with PCin=0x010, immIn=0x00001000, ALU=0x11, Mem=0x22, write x1..x5 with src 0..4.
  - x1=0x11
  - x2=0x22
  - x3=0x14
  - x4=0x1000
  - x5=0x1010
  - src=3'b111 with ALU=0x33 writes 0x33.
- Bypass:
  - Stimulus: write x7=0xCAFEF00D while RdAddrA=7 and RdAddrB=7 in the same cycle.
  - Required: both ports show 0xCAFEF00D before the edge. With RegWrtEn=0 the ports show the old value.
- Trace and counter:
  - Stimulus: three commits to x1, x2, x3, then an idle cycle.
  - Required: TraceValid pulses a cycle behind each commit, TraceDst follows 1, 2, 3, CommitCount=3, and TraceValid=0 on the idle cycle.
- Counter wrap: force CommitCount=0xFFFFFFFF by backdoor, then commit once -> CommitCount=0.
- Mid-stream reset: commit x9=0xAA, then assert rst on the same cycle as a commit of x9=0xBB -> after reset x9=0 and Trace=0.
